// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-style LCD bus responder: opcodes,
// FSM states, DDRAM geometry and the address helper functions.
package lcd_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_CLEAR} state_e;

    localparam int DD_LINE_LEN = 40;
    localparam int DD_CELLS    = 80;
    localparam int CG_CELLS    = 64;

    localparam logic [6:0] LINE0_BASE = 7'h00;
    localparam logic [6:0] LINE1_BASE = 7'h40;

    // Instruction class is selected by the highest set bit of the opcode.
    localparam logic [7:0] OP_CLEAR  = 8'h01;
    localparam logic [7:0] OP_HOME   = 8'h02;
    localparam logic [7:0] OP_ENTRY  = 8'h04;
    localparam logic [7:0] OP_DISP   = 8'h08;
    localparam logic [7:0] OP_SHIFT  = 8'h10;
    localparam logic [7:0] OP_FUNC   = 8'h20;
    localparam logic [7:0] OP_CGADDR = 8'h40;
    localparam logic [7:0] OP_DDADDR = 8'h80;

    // DDRAM address (two 40-cell lines at 0x00 and 0x40) to flat index 0..79.
    function automatic logic [6:0] dd_index(input logic [6:0] a);
        if (a >= LINE1_BASE) return a - LINE1_BASE + 7'(DD_LINE_LEN);
        return a;
    endfunction

    // Out-of-line DDRAM addresses snap to the start of the following line.
    function automatic logic [6:0] dd_addr_fix(input logic [6:0] a);
        if (a >= LINE0_BASE + 7'(DD_LINE_LEN) && a < LINE1_BASE) return LINE1_BASE;
        if (a >= LINE1_BASE + 7'(DD_LINE_LEN)) return LINE0_BASE;
        return a;
    endfunction

    // Address counter step: CGRAM wraps mod 64, DDRAM hops between lines.
    function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc,
                                           input logic cg);
        if (cg) return {1'b0, (inc ? a[5:0] + 6'd1 : a[5:0] - 6'd1)};
        if (inc) begin
            if (a == LINE0_BASE + 7'(DD_LINE_LEN - 1)) return LINE1_BASE;
            if (a == LINE1_BASE + 7'(DD_LINE_LEN - 1)) return LINE0_BASE;
            return a + 7'd1;
        end
        if (a == LINE0_BASE) return LINE1_BASE + 7'(DD_LINE_LEN - 1);
        if (a == LINE1_BASE) return LINE0_BASE + 7'(DD_LINE_LEN - 1);
        return a - 7'd1;
    endfunction

endpackage

// File: rtl/lcd_bus_sync.sv
// Synchronizes the asynchronous LCD bus pins and turns a falling enable
// into a one-cycle transfer strobe carrying the last sampled rs/rw/data.
module lcd_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    input  logic       rs_i,
    input  logic       rw_i,
    input  logic [7:0] data_i,
    output logic       en_s,
    output logic       rs_s,
    output logic       rw_s,
    output logic       xfer,
    output logic       x_rs,
    output logic       x_rw,
    output logic [7:0] x_data
);

    logic [SYNC_STAGES-1:0][10:0] sync_q, sync_d;
    logic [9:0] cap_q, cap_d;
    logic       en_prev_q, en_prev_d;
    logic [7:0] data_s;

    assign {en_s, rs_s, rw_s, data_s} = sync_q[SYNC_STAGES-1];
    assign xfer = en_prev_q & ~en_s;
    assign {x_rs, x_rw, x_data} = cap_q;

    // Shift chain, capture while enabled, and previous-enable for edge detect.
    always_comb begin
        sync_d[0] = {en_i, rs_i, rw_i, data_i};
        for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
        cap_d     = en_s ? {rs_s, rw_s, data_s} : cap_q;
        en_prev_d = en_s;
    end

    // Registers for the synchronizer and capture stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q    <= '0;
            cap_q     <= '0;
            en_prev_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            cap_q     <= cap_d;
            en_prev_q <= en_prev_d;
        end
    end

endmodule

// File: rtl/lcd_sink.sv
// LCD bus responder: decodes writer transfers into a DDRAM/CGRAM display
// model with address counter, control flags and mirror read ports.
module lcd_sink import lcd_pkg::*; #(
    parameter int         SYNC_STAGES = 2,
    parameter int         EXEC_CYCLES = 4,
    parameter logic [7:0] CLEAR_FILL  = 8'h20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lcd_en,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic [7:0] lcd_data,
    output logic [7:0] lcd_q,
    input  logic [6:0] rd_addr,
    output logic [7:0] rd_data,
    input  logic [5:0] cg_rd_addr,
    output logic [7:0] cg_rd_data,
    output logic [6:0] ac,
    output logic       busy,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       two_line,
    output logic       overrun
);

    logic       en_s, rs_s, rw_s, xfer, x_rs, x_rw;
    logic [7:0] x_data;

    lcd_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk(clk), .rst(rst), .en_i(lcd_en), .rs_i(lcd_rs), .rw_i(lcd_rw),
        .data_i(lcd_data), .en_s(en_s), .rs_s(rs_s), .rw_s(rw_s), .xfer(xfer),
        .x_rs(x_rs), .x_rw(x_rw), .x_data(x_data)
    );

    state_e     state_q, state_d;
    logic [6:0] ac_q, ac_d, cnt_q, cnt_d;
    logic       id_q, id_d, cg_mode_q, cg_mode_d, ovr_q, ovr_d;
    logic       disp_q, disp_d, cur_q, cur_d, blink_q, blink_d, two_q, two_d;
    logic [7:0] lcd_q_q, lcd_q_d, rd_data_q;
    logic [4:0] cg_rd_q;

    logic [7:0] ddram [DD_CELLS];
    logic [4:0] cgram [CG_CELLS];
    logic       dd_we, cg_we;
    logic [6:0] dd_widx;
    logic [7:0] dd_wdata, bus_rd;

    assign busy       = (state_q != ST_IDLE);
    assign ac         = ac_q;
    assign disp_on    = disp_q;
    assign cursor_on  = cur_q;
    assign blink_on   = blink_q;
    assign two_line   = two_q;
    assign overrun    = ovr_q;
    assign lcd_q      = lcd_q_q;
    assign rd_data    = rd_data_q;
    assign cg_rd_data = {3'b000, cg_rd_q};
    assign bus_rd     = cg_mode_q ? {3'b000, cgram[ac_q[5:0]]} : ddram[dd_index(ac_q)];

    // Next-state: FSM, instruction/data decode, memory write port, read-back.
    always_comb begin
        state_d = state_q;  ac_d = ac_q;  cnt_d = cnt_q;  id_d = id_q;
        cg_mode_d = cg_mode_q;  ovr_d = ovr_q;  disp_d = disp_q;  cur_d = cur_q;
        blink_d = blink_q;  two_d = two_q;  lcd_q_d = lcd_q_q;
        dd_we = 1'b0;  dd_widx = dd_index(ac_q);  dd_wdata = x_data;  cg_we = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                dd_we    = 1'b1;
                dd_widx  = cnt_q;
                dd_wdata = CLEAR_FILL;
                cnt_d    = cnt_q + 7'd1;
                if (cnt_q == 7'(DD_CELLS - 1)) begin
                    state_d = ST_IDLE;  cnt_d = '0;  ac_d = '0;  id_d = 1'b1;  cg_mode_d = 1'b0;
                end
            end
            ST_EXEC: begin
                cnt_d = cnt_q + 7'd1;
                if (cnt_q == 7'(EXEC_CYCLES - 1)) begin
                    state_d = ST_IDLE;  cnt_d = '0;
                end
            end
            default: begin
                if (xfer && x_rw) begin
                    // Data read steps ac; busy-flag read has no side effect.
                    if (x_rs) ac_d = ac_step(ac_q, id_q, cg_mode_q);
                end else if (xfer) begin
                    state_d = ST_EXEC;
                    cnt_d   = '0;
                    if (x_rs) begin
                        dd_we = ~cg_mode_q;
                        cg_we = cg_mode_q;
                        ac_d  = ac_step(ac_q, id_q, cg_mode_q);
                    end else if (|(x_data & OP_DDADDR)) begin
                        cg_mode_d = 1'b0;  ac_d = dd_addr_fix(x_data[6:0]);
                    end else if (|(x_data & OP_CGADDR)) begin
                        cg_mode_d = 1'b1;  ac_d = {1'b0, x_data[5:0]};
                    end else if (|(x_data & OP_FUNC)) begin
                        two_d = x_data[3];
                    end else if (|(x_data & OP_SHIFT)) begin
                        if (!x_data[3]) ac_d = ac_step(ac_q, x_data[2], cg_mode_q);
                    end else if (|(x_data & OP_DISP)) begin
                        {disp_d, cur_d, blink_d} = x_data[2:0];
                    end else if (|(x_data & OP_ENTRY)) begin
                        id_d = x_data[1];
                    end else if (|(x_data & OP_HOME)) begin
                        ac_d = '0;  cg_mode_d = 1'b0;
                    end else if (|(x_data & OP_CLEAR)) begin
                        state_d = ST_CLEAR;
                    end
                end
            end
        endcase
        // Writes arriving while busy are dropped and flagged; reads still serviced.
        if (xfer && !x_rw && busy) ovr_d = 1'b1;
        if (en_s && rw_s) lcd_q_d = rs_s ? bus_rd : {busy, ac_q};
    end

    // Control state registers; reset restarts the clear fill.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_CLEAR;  ac_q <= '0;  cnt_q <= '0;  id_q <= 1'b1;
            cg_mode_q <= 1'b0;  ovr_q <= 1'b0;  disp_q <= 1'b0;  cur_q <= 1'b0;
            blink_q <= 1'b0;  two_q <= 1'b0;  lcd_q_q <= '0;
        end else begin
            state_q <= state_d;  ac_q <= ac_d;  cnt_q <= cnt_d;  id_q <= id_d;
            cg_mode_q <= cg_mode_d;  ovr_q <= ovr_d;  disp_q <= disp_d;  cur_q <= cur_d;
            blink_q <= blink_d;  two_q <= two_d;  lcd_q_q <= lcd_q_d;
        end
    end

    // Dual-port memories: bus-side writes, independent mirror reads.
    always_ff @(posedge clk) begin
        if (dd_we && !rst) ddram[dd_widx] <= dd_wdata;
        if (cg_we && !rst) cgram[ac_q[5:0]] <= x_data[4:0];
        rd_data_q <= (rd_addr < 7'(DD_CELLS)) ? ddram[rd_addr] : 8'h00;
        cg_rd_q   <= cgram[cg_rd_addr];
    end

endmodule

// File: tb/tb_lcd_sink.sv
// Directed bench for lcd_sink: stimulus pushes expected values into a
// scoreboard queue, a monitor pops and compares one cycle later.
module tb_lcd_sink;

    localparam int K_RD = 0, K_CG = 1, K_AC = 2, K_BUSY = 3, K_DISP = 4,
                   K_CUR = 5, K_TWO = 6, K_OVR = 7, K_LCDQ = 8, K_VAL = 9;

    typedef struct {
        string name;
        int    kind;
        int    exp;
        int    act;
    } chk_t;

    logic       clk = 1'b0, rst = 1'b1;
    logic       lcd_en = 1'b0, lcd_rs = 1'b0, lcd_rw = 1'b0;
    logic [7:0] lcd_data = 8'h00;
    logic [7:0] lcd_q, rd_data, cg_rd_data;
    logic [6:0] rd_addr = '0, ac;
    logic [5:0] cg_rd_addr = '0;
    logic       busy, disp_on, cursor_on, blink_on, two_line, overrun;

    chk_t sb[$];
    chk_t mc;
    int   mact;
    int   n_chk = 0, n_pass = 0;
    logic probe = 1'b0, probe_d = 1'b0;

    lcd_sink dut (
        .clk(clk), .rst(rst), .lcd_en(lcd_en), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
        .lcd_data(lcd_data), .lcd_q(lcd_q), .rd_addr(rd_addr), .rd_data(rd_data),
        .cg_rd_addr(cg_rd_addr), .cg_rd_data(cg_rd_data), .ac(ac), .busy(busy),
        .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on),
        .two_line(two_line), .overrun(overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) probe_d <= probe;

    // Monitor: each probe yields one DUT response, compared against the queue head.
    always @(negedge clk) begin
        if (probe_d) begin
            if (sb.size() == 0) begin
                n_chk++;
                $display("FAIL scoreboard_underflow: response with no expectation");
            end else begin
                mc = sb.pop_front();
                case (mc.kind)
                    K_RD:    mact = int'(rd_data);
                    K_CG:    mact = int'(cg_rd_data);
                    K_AC:    mact = int'(ac);
                    K_BUSY:  mact = int'(busy);
                    K_DISP:  mact = int'(disp_on);
                    K_CUR:   mact = int'(cursor_on);
                    K_TWO:   mact = int'(two_line);
                    K_OVR:   mact = int'(overrun);
                    K_LCDQ:  mact = int'(lcd_q);
                    default: mact = mc.act;
                endcase
                n_chk++;
                if (mact == mc.exp) n_pass++;
                else $display("FAIL %s: got 0x%0h expected 0x%0h", mc.name, mact, mc.exp);
            end
        end
    end

    task automatic chk(input string name, input int kind, input int exp,
                       input int addr = 0, input int act = 0);
        chk_t c;
        c.name = name;  c.kind = kind;  c.exp = exp;  c.act = act;
        rd_addr    = 7'(addr);
        cg_rd_addr = 6'(addr);
        sb.push_back(c);
        probe = 1'b1;
        @(negedge clk);
        probe = 1'b0;
    endtask

    task automatic bus_pulse(input logic rs, input logic rw, input logic [7:0] d);
        lcd_rs = rs;  lcd_rw = rw;  lcd_data = d;  lcd_en = 1'b1;
        repeat (4) @(negedge clk);
        lcd_en = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            n_chk++;
            $display("FAIL wait_idle: busy still 1 after %0d cycles, required 0", n);
        end
    endtask

    task automatic wr(input logic rs, input logic [7:0] d);
        bus_pulse(rs, 1'b0, d);
        repeat (5) @(negedge clk);
        wait_idle();
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 500) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        int n;
        logic [7:0] cgv [8];
        cgv = '{8'h04, 8'h02, 8'h07, 8'h0D, 8'h1F, 8'h17, 8'h14, 8'h03};

        // Power-on reset and fill
        repeat (3) @(negedge clk);
        rst = 1'b0;
        count_busy(n);
        chk("reset_busy_cycles", K_VAL, 80, 0, n);
        chk("reset_dd0", K_RD, 8'h20, 0);
        chk("reset_dd39", K_RD, 8'h20, 39);
        chk("reset_dd40", K_RD, 8'h20, 40);
        chk("reset_dd79", K_RD, 8'h20, 79);
        chk("reset_dd80_oob", K_RD, 8'h00, 80);
        chk("reset_ac", K_AC, 0);
        chk("reset_disp", K_DISP, 0);
        chk("reset_ovr", K_OVR, 0);
        chk("reset_lcdq", K_LCDQ, 0);

        // Init sequence and "HI"
        wr(0, 8'h38); wr(0, 8'h08); wr(0, 8'h01); wr(0, 8'h06);
        wr(0, 8'h0C); wr(0, 8'h80); wr(1, 8'h48); wr(1, 8'h49);
        chk("init_two_line", K_TWO, 1);
        chk("init_disp_on", K_DISP, 1);
        chk("init_cursor_off", K_CUR, 0);
        chk("hi_dd0", K_RD, 8'h48, 0);
        chk("hi_dd1", K_RD, 8'h49, 1);
        chk("hi_ac", K_AC, 8'h02);

        // Busy-flag/address read, then data read with ac step
        lcd_rs = 1'b0;  lcd_rw = 1'b1;  lcd_en = 1'b1;
        repeat (4) @(negedge clk);
        chk("read_bf_ac", K_LCDQ, 8'h02);
        lcd_en = 1'b0;
        repeat (6) @(negedge clk);
        wr(0, 8'h80);
        lcd_rs = 1'b1;  lcd_rw = 1'b1;  lcd_en = 1'b1;
        repeat (4) @(negedge clk);
        chk("read_data_dd0", K_LCDQ, 8'h48);
        lcd_en = 1'b0;
        repeat (6) @(negedge clk);
        chk("read_data_ac_step", K_AC, 8'h01);

        // Line wrap 0x27 -> 0x40 and decrement wrap 0x00 -> 0x67
        wr(0, 8'hA7); wr(1, 8'h41); wr(1, 8'h42);
        chk("wrap_dd39", K_RD, 8'h41, 39);
        chk("wrap_dd40", K_RD, 8'h42, 40);
        chk("wrap_ac", K_AC, 8'h41);
        wr(0, 8'h04); wr(0, 8'h80); wr(1, 8'h5A);
        chk("dec_wrap_ac", K_AC, 8'h67);
        chk("dec_wrap_dd0", K_RD, 8'h5A, 0);

        // CGRAM glyph load, then return to DDRAM
        wr(0, 8'h06); wr(0, 8'h40);
        for (int i = 0; i < 8; i++) wr(1, cgv[i]);
        for (int i = 0; i < 8; i++) chk($sformatf("cg%0d", i), K_CG, int'(cgv[i]), i);
        chk("cg_ac", K_AC, 8'h08);
        wr(0, 8'h80);
        chk("dd_return_ac", K_AC, 0);
        wr(1, 8'h51);
        chk("dd_return_dd0", K_RD, 8'h51, 0);
        chk("dd_return_ac_step", K_AC, 1);

        // Write during clear is discarded and flagged
        bus_pulse(0, 0, 8'h01);
        repeat (5) @(negedge clk);
        bus_pulse(1, 0, 8'h58);
        repeat (5) @(negedge clk);
        wait_idle();
        chk("ovr_set", K_OVR, 1);
        for (int i = 0; i < 80; i++) chk($sformatf("clr_dd%0d", i), K_RD, 8'h20, i);

        // Reset 40 cycles into a clear restarts the full fill
        bus_pulse(0, 0, 8'h01);
        repeat (3) @(negedge clk);
        chk("clear_busy", K_BUSY, 1);
        repeat (39) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        count_busy(n);
        chk("rst_mid_busy_cycles", K_VAL, 80, 0, n);
        chk("rst_mid_ac", K_AC, 0);
        chk("rst_mid_ovr", K_OVR, 0);
        chk("rst_mid_dd0", K_RD, 8'h20, 0);

        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            n_chk++;
            $display("FAIL scoreboard_drain: %0d left, required 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/lcd_sink.md
Name: lcd_sink

Overview:
- Responder end of the HD44780-style 8-bit parallel LCD bus that our LCD writer drives.
- Samples lcd_en/lcd_rs/lcd_rw/lcd_data, decodes each transfer, and maintains a synthesizable model of the display:
  - DDRAM: 80 bytes.
  - CGRAM: 64 bytes.
  - Address counter and control flags.
- Used on-chip as a display mirror (VGA/UART readback) and as the bus-functional checker for the writer.

Parameters:
- SYNC_STAGES, 2: synchronizer depth on all bus inputs (minimum 2).
- EXEC_CYCLES, 4: busy duration in clk cycles for every instruction except clear.
- CLEAR_FILL, 8'h20: byte written to all DDRAM cells on clear and after reset.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- lcd_en  in  1  bus enable; a transfer is latched on its falling edge
- lcd_rs  in  1  0 = instruction, 1 = data
- lcd_rw  in  1  0 = write, 1 = read
- lcd_data  in  8  bus data from the writer
- lcd_q  out  8  read-back data; valid while synchronized en is high and rw = 1
- rd_addr  in  7  mirror read index 0..79 (0..39 = line 0, 40..79 = line 1)
- rd_data  out  8  DDRAM byte at rd_addr, 1-cycle latency
- cg_rd_addr  in  6  CGRAM mirror read address
- cg_rd_data  out  8  CGRAM byte, bits [4:0] valid, 1-cycle latency
- ac  out  7  address counter
- busy  out  1  instruction in progress
- disp_on, cursor_on, blink_on  out  1 each  display-control flags
- two_line  out  1  function-set N bit
- overrun  out  1  sticky: a transfer arrived while busy

Behaviour:
- Input capture
  - All bus inputs pass through SYNC_STAGES flops.
  - rs/rw/data are captured every cycle while synchronized en = 1.
  - A synchronized en fall produces a one-cycle `xfer` strobe using the last captured values.
  - Decode takes effect SYNC_STAGES+1 cycles after the pin falls.
- Reset
  - Outputs after reset: ac = 0, disp_on = cursor_on = blink_on = 0, two_line = 0, overrun = 0, lcd_q = 0, I/D = 1, addressing mode = DDRAM.
  - FSM enters CLEAR: busy = 1 for 80 cycles, writing CLEAR_FILL to DDRAM index 0..79 one per cycle, then IDLE.
  - CGRAM is not initialised.
  - Reset asserted mid-operation aborts it and restarts the CLEAR sequence.
- FSM states
  - IDLE: on xfer, decode and go to EXEC; or go to CLEAR for 0x01.
  - EXEC: count EXEC_CYCLES, then IDLE.
  - CLEAR: 80-cycle fill. At end, ac = 0, I/D = 1, mode = DDRAM, then IDLE.
- Busy and overrun
  - busy = 1 in EXEC and CLEAR.
  - A write xfer while busy is discarded and sets overrun.
  - A read xfer while busy is serviced (busy-flag read).
- Instruction decode (rs = 0, rw = 0), by highest set bit of data:
  - 0x01: clear.
  - 0x02/0x03: ac = 0, mode = DDRAM.
  - 0x04–0x07: store I/D = d[1]; the shift bit is stored and ignored.
  - 0x08–0x0F: disp_on = d[2], cursor_on = d[1], blink_on = d[0].
  - 0x10–0x1F: if S/C = 0, ac moves ±1 per R/L using the wrap rules below; display shift is ignored.
  - 0x20–0x3F: two_line = d[3]; DL and F are stored, with no other effect.
  - 0x40–0x7F: mode = CGRAM, ac = {1'b0, d[5:0]}.
  - 0x80–0xFF: mode = DDRAM, ac = d[6:0]. Addresses 0x28–0x3F and 0x68–0x7F are forced to 0x40 and 0x00 respectively.
- Data write (rs = 1, rw = 0)
  - Stores data at ac in the current mode: CGRAM stores data[4:0].
  - Then ac steps by I/D.
  - DDRAM increment wraps 0x27 → 0x40 and 0x67 → 0x00.
  - DDRAM decrement wraps 0x00 → 0x67 and 0x40 → 0x27.
  - CGRAM wraps modulo 64.
- Reads (rw = 1)
  - rs = 0: lcd_q = {busy, ac}.
  - rs = 1: lcd_q = memory byte at ac; ac steps at the en fall.
- Index mapping
  - DDRAM address 0x00–0x27 maps to index 0–39.
  - DDRAM address 0x40–0x67 maps to index 40–79.
- Mirror ports
  - rd_addr ≥ 80 returns 8'h00.
  - Mirror reads never disturb the bus side: dual-port RAM, bus side has write priority for internal state.

Decomposition:
- Package lcd_pkg holds:
  - Instruction opcode masks and values.
  - The FSM state enum (IDLE/EXEC/CLEAR).
  - DDRAM line base addresses and line length (40).
  - The addr-to-index function and the ac-step function.
- One sub-module, lcd_bus_sync: synchronizer plus en-fall strobe generator with captured rs/rw/data.

Test Plan:
- Reset, wait 80 cycles → busy falls after exactly 80 cycles; rd_data = 8'h20 for indices 0, 39, 40, 79; ac = 0.
- Write 0x38, 0x08, 0x01, 0x06, 0x0C, 0x80, then 'H', 'I' (respecting busy) → two_line = 1, disp_on = 1, cursor_on = 0; rd_data[0] = 8'h48, rd_data[1] = 8'h49; ac = 8'h02.
- Write 0xA7, then 'A', 'B' → index 39 = 8'h41, index 40 = 8'h42, ac = 8'h41. Write 0x04, 0x80, then data → ac wraps to 0x67.
- Write 0x40, then 8 bytes 04, 02, 07, 0D, 1F, 17, 14, 03 → cg_rd_data[0..7] match; ac = 0x08; 0x80 returns to DDRAM mode with ac = 0.
- Write 0x01, then a data write 5 cycles later → data discarded, overrun = 1, DDRAM all 8'h20.
- Assert rst at cycle 40 of a clear → ac = 0, overrun = 0, busy restarts a full 80-cycle fill.
